// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared definitions for the seven-segment display blocks:
//               display mode encodings and active-low segment codes
//               (bit0 = a ... bit6 = g, bit7 = dp; 0 lights the segment).
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_STATIC = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_BLINK  = 2'b11
  } ssd_mode_e;

  localparam logic [7:0] SS_BLANK = 8'hFF;

  localparam logic [7:0] SS_0 = 8'hC0;
  localparam logic [7:0] SS_1 = 8'hF9;
  localparam logic [7:0] SS_2 = 8'hA4;
  localparam logic [7:0] SS_3 = 8'hB0;
  localparam logic [7:0] SS_4 = 8'h99;
  localparam logic [7:0] SS_5 = 8'h92;
  localparam logic [7:0] SS_6 = 8'h82;
  localparam logic [7:0] SS_7 = 8'hF8;
  localparam logic [7:0] SS_8 = 8'h80;
  localparam logic [7:0] SS_9 = 8'h90;

  // Letter glyphs used by the top-level message ("NTHUEECS")
  localparam logic [7:0] SS_N = 8'hAB;
  localparam logic [7:0] SS_T = 8'h87;
  localparam logic [7:0] SS_H = 8'h89;
  localparam logic [7:0] SS_U = 8'hC1;
  localparam logic [7:0] SS_E = 8'h86;
  localparam logic [7:0] SS_C = 8'hC6;
  localparam logic [7:0] SS_S = 8'h92;

endpackage : ssd_pkg
`default_nettype wire

// File: rtl/ssd_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_timer
// Description : Refresh prescaler plus digit-index counter. slot_tick marks
//               the last clk of each digit slot; digit_idx advances on it.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_timer #(
  parameter int SCAN_DIV   = 1024,
  parameter int NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          slot_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] c_cnt_last = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] c_idx_last = DW'(NUM_DIGITS - 1);

  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_idx;

  assign slot_tick = (r_cnt == c_cnt_last);
  assign digit_idx = r_idx;

  // Prescaler 0..SCAN_DIV-1, then digit index wraps modulo NUM_DIGITS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (slot_tick) begin
      r_cnt <= '0;
      r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + DW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule : ssd_scan_timer
`default_nettype wire

// File: rtl/ssd_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scroll_ctrl
// Description : Seven-segment scroll controller. Holds a MSG_DEPTH-entry
//               segment buffer and multiplexes a NUM_DIGITS-wide window of it
//               onto pattern/anode; window can be static, rotating, blinking
//               or blanked.
//               Optional macro SSD_SCROLL_DP_EN adds dp_mask, which forces the
//               decimal point on for masked buffer entries.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scroll_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_DEPTH  = 8,
  parameter int SCAN_DIV   = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick_slow,
  input  logic [1:0]                   mode,
  input  logic                         dir,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [7:0]                   wr_data,
`ifdef SSD_SCROLL_DP_EN
  input  logic [MSG_DEPTH-1:0]         dp_mask,
`endif
  output logic [7:0]                   pattern,
  output logic [NUM_DIGITS-1:0]        anode,
  output logic [$clog2(MSG_DEPTH)-1:0] offset
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [AW:0] c_one       = (AW+1)'(1);
  localparam logic [AW:0] c_depth     = (AW+1)'(MSG_DEPTH);
  localparam logic [AW:0] c_last_ent  = (AW+1)'(MSG_DEPTH - 1);
  localparam logic [AW:0] c_last_col  = (AW+1)'(NUM_DIGITS - 1);

  ssd_mode_e             w_mode;
  ssd_mode_e             r_mode_q;
  logic                  r_dark;
  logic [7:0]            r_buf [MSG_DEPTH];
  logic [AW-1:0]         r_offset;
  logic [7:0]            r_pattern;
  logic [NUM_DIGITS-1:0] r_anode;

  logic [DW-1:0]         w_digit_idx;
  logic                  w_slot_tick_unused;  // outputs reload every clk, slot edge not needed
  logic                  w_wr_ok;
  logic [AW:0]           w_off_ext;
  logic [AW:0]           w_sum;
  logic [AW-1:0]         w_rd_idx;
  logic [AW-1:0]         w_off_inc;
  logic [AW-1:0]         w_off_dec;
  logic [7:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_onehot_n;

  assign w_mode  = ssd_mode_e'(mode);
  assign pattern = r_pattern;
  assign anode   = r_anode;
  assign offset  = r_offset;

  ssd_scan_timer #(
    .SCAN_DIV   (SCAN_DIV),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit_idx (w_digit_idx),
    .slot_tick (w_slot_tick_unused)
  );

  // Index arithmetic carried one bit wider than the buffer address so the
  // sum of offset and column never overflows before the single-step modulo.
  assign w_wr_ok   = ({1'b0, wr_addr} < c_depth);
  assign w_off_ext = {1'b0, r_offset};
  assign w_sum     = w_off_ext + c_last_col - (AW+1)'(w_digit_idx);
  assign w_rd_idx  = AW'((w_sum >= c_depth) ? (w_sum - c_depth) : w_sum);
  assign w_off_inc = (w_off_ext == c_last_ent) ? '0 : AW'(w_off_ext + c_one);
  assign w_off_dec = (r_offset == '0) ? AW'(c_last_ent) : AW'(w_off_ext - c_one);
  assign w_onehot_n = ~(NUM_DIGITS'(1) << w_digit_idx);

  // Segment code for the digit currently being scanned
  always_comb begin
    w_seg = r_buf[w_rd_idx];
`ifdef SSD_SCROLL_DP_EN
    if (dp_mask[w_rd_idx]) begin
      w_seg[7] = 1'b0;
    end
`endif
  end

  // Message buffer: clear wins over a same-cycle write; out-of-range writes drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_DEPTH; i++) r_buf[i] <= SS_BLANK;
    end else if (clear) begin
      for (int i = 0; i < MSG_DEPTH; i++) r_buf[i] <= SS_BLANK;
    end else if (wr_en && w_wr_ok) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  // Window start: cleared by clear or IDLE, stepped with explicit wrap in ROTATE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset <= '0;
    end else if (clear || (w_mode == MODE_IDLE)) begin
      r_offset <= '0;
    end else if ((w_mode == MODE_ROTATE) && tick_slow) begin
      r_offset <= dir ? w_off_dec : w_off_inc;
    end
  end

  // Mode history and blink phase; phase restarts visible on entry to BLINK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= MODE_IDLE;
      r_dark   <= 1'b0;
    end else begin
      r_mode_q <= w_mode;
      if ((w_mode != MODE_BLINK) || (r_mode_q != MODE_BLINK)) begin
        r_dark <= 1'b0;
      end else if (tick_slow) begin
        r_dark <= ~r_dark;
      end
    end
  end

  // Registered pin drivers; dark blink phase only suppresses the anodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= SS_BLANK;
      r_anode   <= '1;
    end else if (w_mode == MODE_IDLE) begin
      r_pattern <= SS_BLANK;
      r_anode   <= '1;
    end else begin
      r_pattern <= w_seg;
      r_anode   <= ((w_mode == MODE_BLINK) && r_dark) ? '1 : w_onehot_n;
    end
  end

endmodule : ssd_scroll_ctrl
`default_nettype wire

// File: tb/tb_ssd_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scroll_ctrl
// Description : Self-checking bench for ssd_scroll_ctrl. Two instances share
//               stimulus: an 8-entry buffer and a 6-entry (non power of two)
//               buffer, both 4 digits with a 4-clk refresh slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scroll_ctrl;
  import ssd_pkg::*;

  localparam int N  = 4;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_slow = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       dir = 1'b0;
  logic       clear = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'h00;

  logic [7:0] pat8, pat6;
  logic [3:0] an8, an6;
  logic [2:0] off8, off6;
`ifdef SSD_SCROLL_DP_EN
  logic [7:0] dpm8 = '0;
  logic [5:0] dpm6 = '0;
`endif

  always #5 clk = ~clk;

  ssd_scroll_ctrl #(.NUM_DIGITS(N), .MSG_DEPTH(8), .SCAN_DIV(SD)) dut8 (
    .clk(clk), .rst_n(rst_n), .tick_slow(tick_slow), .mode(mode), .dir(dir),
    .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef SSD_SCROLL_DP_EN
    .dp_mask(dpm8),
`endif
    .pattern(pat8), .anode(an8), .offset(off8)
  );

  ssd_scroll_ctrl #(.NUM_DIGITS(N), .MSG_DEPTH(6), .SCAN_DIV(SD)) dut6 (
    .clk(clk), .rst_n(rst_n), .tick_slow(tick_slow), .mode(mode), .dir(dir),
    .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef SSD_SCROLL_DP_EN
    .dp_mask(dpm6),
`endif
    .pattern(pat6), .anode(an6), .offset(off6)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Digit index is derived from the clk count since reset; the window maps
  // the leftmost digit to buf[offset] and proceeds rightwards modulo depth.
  logic [7:0] mb8 [8];
  logic [7:0] mb6 [6];
  int         mo8, mo6, mk, md;
  bit         mdark;
  logic [1:0] mprev;
  logic [7:0] ep8, ep6;
  logic [3:0] ea8, ea6;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (mb8[i]) mb8[i] = SS_BLANK;
      foreach (mb6[i]) mb6[i] = SS_BLANK;
      mo8 = 0; mo6 = 0; mk = 0; mdark = 1'b0; mprev = 2'b00;
      ep8 = SS_BLANK; ep6 = SS_BLANK; ea8 = 4'hF; ea6 = 4'hF;
    end else begin
      md = (mk / SD) % N;
      if (mode == 2'b00) begin
        ep8 = SS_BLANK; ep6 = SS_BLANK; ea8 = 4'hF; ea6 = 4'hF;
      end else begin
        ep8 = mb8[(mo8 + N - 1 - md) % 8];
        ep6 = mb6[(mo6 + N - 1 - md) % 6];
        ea8 = (mode == 2'b11 && mdark) ? 4'hF : (4'hF ^ (4'b0001 << md));
        ea6 = ea8;
      end
      if (clear) begin
        foreach (mb8[i]) mb8[i] = SS_BLANK;
        foreach (mb6[i]) mb6[i] = SS_BLANK;
        mo8 = 0; mo6 = 0;
      end else begin
        if (wr_en) begin
          mb8[wr_addr] = wr_data;
          if (wr_addr < 3'd6) mb6[wr_addr] = wr_data;
        end
        if (mode == 2'b00) begin
          mo8 = 0; mo6 = 0;
        end else if (mode == 2'b10 && tick_slow) begin
          mo8 = dir ? (mo8 + 7) % 8 : (mo8 + 1) % 8;
          mo6 = dir ? (mo6 + 5) % 6 : (mo6 + 1) % 6;
        end
      end
      if (mode == 2'b11 && mprev == 2'b11) begin
        if (tick_slow) mdark = !mdark;
      end else begin
        mdark = 1'b0;
      end
      mprev = mode;
      mk++;
    end
  end

  // Continuous comparison of both instances against the model
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      cmp("m8.pattern", pat8, ep8);
      cmp("m8.anode",   an8,  ea8);
      cmp("m8.offset",  off8, mo8);
      cmp("m6.pattern", pat6, ep6);
      cmp("m6.anode",   an6,  ea6);
      cmp("m6.offset",  off6, mo6);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_tick();
    tick_slow = 1'b1;
    @(negedge clk);
    tick_slow = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_an(input string nm, input bit sel6, input logic [3:0] a, output bit found);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if ((sel6 ? an6 : an8) === a) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: anode %b not reached within 64 clks", nm, a);
    end
  endtask

  task automatic check_digit(input string nm, input bit sel6, input logic [3:0] a, input logic [7:0] p);
    bit ok;
    wait_an(nm, sel6, a, ok);
    if (ok) cmp(nm, sel6 ? pat6 : pat8, p);
  endtask

  task automatic write_msg();
    logic [7:0] msg [8];
    msg = '{SS_N, SS_T, SS_H, SS_U, SS_E, SS_E, SS_C, SS_S};
    for (int i = 0; i < 8; i++) wr(3'(i), msg[i]);
  endtask

  typedef struct {
    logic [3:0] an;
    logic [7:0] pat;
  } slot_t;

  typedef struct {
    logic [1:0] mode;
    bit         dir;
    bit         tick;
    bit         clr;
    logic [2:0] exp_off8;
    logic [2:0] exp_off6;
  } vec_t;

  slot_t st [4];
  vec_t  vt [11];

  task automatic apply_vec(input int i);
    mode = vt[i].mode; dir = vt[i].dir;
    tick_slow = vt[i].tick; clear = vt[i].clr;
    @(negedge clk);
    tick_slow = 1'b0; clear = 1'b0;
    cmp($sformatf("vec%0d.off8", i), off8, vt[i].exp_off8);
    cmp($sformatf("vec%0d.off6", i), off6, vt[i].exp_off6);
  endtask

  initial begin
    bit ok;

    st[0] = '{4'b1110, SS_U};
    st[1] = '{4'b1101, SS_H};
    st[2] = '{4'b1011, SS_T};
    st[3] = '{4'b0111, SS_N};

    // ROTATE left 9 ticks, clear+tick, then one right tick
    for (int i = 0; i < 9; i++)
      vt[i] = '{2'b10, 1'b0, 1'b1, 1'b0, 3'((i + 1) % 8), 3'((i + 1) % 6)};
    vt[9]  = '{2'b10, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0};
    vt[10] = '{2'b10, 1'b1, 1'b1, 1'b0, 3'd7, 3'd5};

    // Reset state
    repeat (2) @(negedge clk);
    cmp("rst.an8", an8, 4'hF);   cmp("rst.pat8", pat8, 8'hFF); cmp("rst.off8", off8, 3'd0);
    cmp("rst.an6", an6, 4'hF);   cmp("rst.pat6", pat6, 8'hFF); cmp("rst.off6", off6, 3'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Static window of "NTHUEECS"
    write_msg();
    mode = 2'b01;
    wait_an("static.sync0", 1'b0, 4'b0111, ok);
    wait_an("static.sync1", 1'b0, 4'b1110, ok);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        cmp($sformatf("static.s%0d.c%0d.an", s, c),  an8,  st[s].an);
        cmp($sformatf("static.s%0d.c%0d.pat", s, c), pat8, st[s].pat);
        @(negedge clk);
      end
    end

    // ROTATE left up to offset 6, freeze and check the wrapped window
    for (int i = 0; i < 6; i++) apply_vec(i);
    mode = 2'b01;
    @(negedge clk);
    check_digit("rotL.d3", 1'b0, 4'b0111, SS_C);
    check_digit("rotL.d2", 1'b0, 4'b1011, SS_S);
    check_digit("rotL.d1", 1'b0, 4'b1101, SS_N);
    check_digit("rotL.d0", 1'b0, 4'b1110, SS_T);
    check_digit("rotL6.d3", 1'b1, 4'b0111, SS_N);
    for (int i = 6; i < 10; i++) apply_vec(i);

    // ROTATE right from 0 on the 6-deep buffer wraps to 5
    write_msg();
    apply_vec(10);
    mode = 2'b01;
    @(negedge clk);
    check_digit("rotR.d3", 1'b1, 4'b0111, SS_E);
    check_digit("rotR.d2", 1'b1, 4'b1011, SS_N);
    check_digit("rotR.d1", 1'b1, 4'b1101, SS_T);
    check_digit("rotR.d0", 1'b1, 4'b1110, SS_H);
    check_digit("rotR8.d3", 1'b0, 4'b0111, SS_S);

    // Out-of-range writes on the 6-deep buffer are dropped
    wr(3'd6, SS_0);
    wr(3'd7, SS_0);
    check_digit("oor.d3", 1'b1, 4'b0111, SS_E);
    check_digit("oor.d2", 1'b1, 4'b1011, SS_N);

    // clear beats a same-cycle write to addr 2
    clear = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = SS_8;
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    cmp("clr.off8", off8, 3'd0);
    cmp("clr.off6", off6, 3'd0);
    check_digit("clr.buf2", 1'b0, 4'b1101, SS_BLANK);
    write_msg();

    // BLINK: dark / visible / dark on successive ticks
    mode = 2'b11;
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      pulse_tick();
      @(negedge clk);
      for (int c = 0; c < 16; c++) begin
        if (p == 1) cmp($sformatf("blink%0d.vis", p), 32'($countones(~an8)), 32'd1);
        else        cmp($sformatf("blink%0d.dark", p), an8, 4'hF);
        @(negedge clk);
      end
    end

    // Async reset in the middle of a rotation
    mode = 2'b10; dir = 1'b0;
    pulse_tick(); pulse_tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst.an8", an8, 4'hF);  cmp("arst.pat8", pat8, 8'hFF); cmp("arst.off8", off8, 3'd0);
    cmp("arst.an6", an6, 4'hF);  cmp("arst.pat6", pat6, 8'hFF); cmp("arst.off6", off6, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2'b00;
    write_msg();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        mode = 2'($urandom_range(0, 3));
        dir  = 1'($urandom_range(0, 1));
      end
      tick_slow = ($urandom_range(0, 7) == 0);
      clear     = ($urandom_range(0, 63) == 0);
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_addr   = 3'($urandom_range(0, 7));
      wr_data   = 8'($urandom);
      @(negedge clk);
    end
    tick_slow = 1'b0; clear = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ssd_scroll_ctrl
`default_nettype wire
